qcl_sync_arb_ctrl: RTL
======================

// Module: qcl_sync_arb_ctrl
// PURPOSE
//  Source-domain scheduler that shares one multi-bit qcl_sync_dff channel among els_p requesters.
//  - Arbitrates round-robin and accepts one word per grant.
//  - Drives the shared src_d_i bus and holds it stable for hold_cycles_p cycles, so the destination
//    never samples a half-changed word.
//  - Sends a toggle tag with each word, so the destination detects a new word by an edge on the tag.
// PARAMETERS
//  els_p          4  number of requesters (>=1)
//  width_p        8  data word width
//  hold_cycles_p  4  source cycles each word is held stable (>=2)
//  id_width_lp    -  localparam = max(1,$clog2(els_p))
// PORTS
//  clk_i          in   1                source clock
//  reset_n_i      in   1                reset, asynchronous, active-low
//  req_v_i        in   els_p            per-requester valid
//  req_data_i     in   els_p*width_p    requester i data at [i*width_p +: width_p]
//  req_ready_o    out  els_p            one-hot accept; word transfers when v&ready
//  sync_data_o    out  width_p          to qcl_sync_dff src_d_i (data field)
//  sync_id_o      out  id_width_lp      index of the requester that owns sync_data_o
//  sync_toggle_o  out  1                flips once per accepted word
//  busy_o         out  1                high while a word is being held
//  stat_cnt_o     out  16               accepted-word count (only with QCL_SYNC_ARB_STATS_EN)
// BEHAVIOUR
//  - States: IDLE, HOLD. Hold counter cnt_r is $clog2(hold_cycles_p) bits wide.
//  - Grant cycle: (IDLE & |req_v_i) or (HOLD & cnt_r==0 & |req_v_i).
//  - In a grant cycle, req_ready_o[g]=1 combinationally for winner g; all other bits are 0.
//  - req_ready_o is Mealy. A requester must not make req_v_i depend on req_ready_o.
//  - At the clock edge ending a grant cycle:
//    - sync_data_o<=data[g], sync_id_o<=g, sync_toggle_o<=~sync_toggle_o
//    - cnt_r<=hold_cycles_p-1, state<=HOLD, rr pointer<=(g+1) mod els_p
//  - HOLD: cnt_r decrements each cycle. At cnt_r==0:
//    - any request -> grant again; words are back-to-back with period hold_cycles_p.
//    - no request -> go to IDLE.
//  - Round-robin: search from the pointer upward and wrap past els_p-1 to 0; first valid wins.
//  - Latency: the word appears on sync_* 1 cycle after acceptance. Outputs never change during HOLD
//    except on a re-grant at cnt_r==0.
//  - busy_o = (state==HOLD).
//  - IDLE outputs keep the last word (no return to 0); only sync_toggle_o marks new data.
//  - Dropping req_v_i before a grant is legal; that requester gets no ready.
//  - Asserting req_v_i during HOLD waits for cnt_r==0.
//  - Reset (async, any time incl. mid-HOLD), all immediately:
//    - sync_data_o=0, sync_id_o=0, sync_toggle_o=0, busy_o=0, req_ready_o=0
//    - state=IDLE, cnt_r=0, rr pointer=0
//    - the destination-side tag tracker must be reset with it.
// CONFIGURATION
//  - QCL_SYNC_ARB_STATS_EN defined:
//    - stat_cnt_o exists; reset 0; +1 per accepted word; wraps 0xFFFF->0x0000.
//  - QCL_SYNC_ARB_STATS_EN not defined: port and counter are absent; all other behaviour identical.
// STRUCTURE
//  - qcl_sync_arb_pkg:
//    - state enum (IDLE=1'b0, HOLD=1'b1)
//    - function for the id-width max(1,clog2)
//  - Sub-module qcl_rr_arb: els_p req vector + pointer in, one-hot grant + encoded index out.
//    Purely combinational; the pointer register lives in qcl_sync_arb_ctrl.
// TESTING (els_p=4, width_p=8, hold_cycles_p=4)
//  1. Reset held, then released, no reqs -> all outputs 0, busy_o=0, state stays IDLE.
//  2. req_v_i=4'b0100, data[2]=8'hA5 -> ready[2] pulses 1 cycle; next edge sync_data_o=A5,
//     id=2, toggle=1; busy_o high exactly 4 cycles.
//  3. req_v_i=4'b1111 held -> grants 0,1,2,3,0 exactly 4 cycles apart; toggle alternates
//     1,0,1,0,1; busy_o never drops.
//  4. After a grant to 1, req_v_i=4'b1010 -> next grant 3, then 1 (wrap order respected).
//  5. reset_n_i low at cnt_r==2 of a HOLD -> outputs 0 in same cycle; after release with
//     4'b1111, first grant is 0.
//  6. STATS_EN defined, 10 accepted words -> stat_cnt_o=10; preload 0xFFFF + 1 word -> 0x0000.

Source files
------------

// File: rtl/qcl_sync_arb_pkg.sv
// qcl_sync_arb_pkg: shared types for the qcl_sync source-side arbiter.
// Holds the controller state enum and the requester-index width helper.
package qcl_sync_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Index width that stays at least one bit for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qcl_sync_arb_ctrl_rr_arb.sv
// qcl_rr_arb: combinational round-robin pick starting at ptr_i.
// Returns a one-hot grant and the encoded winner index.
module qcl_rr_arb
  import qcl_sync_arb_pkg::*;
#(
  parameter int els_p = 4,
  localparam int id_width_lp = id_width(els_p)
) (
  input  logic [els_p-1:0]       req_i,
  input  logic [id_width_lp-1:0] ptr_i,
  output logic [els_p-1:0]       gnt_o,
  output logic [id_width_lp-1:0] idx_o
);

  logic                   hit;
  int                     j;
  logic [id_width_lp-1:0] jj;

  // Scan from the pointer upward, wrapping, first valid wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    hit   = 1'b0;
    j     = 0;
    jj    = '0;
    for (int i = 0; i < els_p; i++) begin
      j = int'(ptr_i) + i;
      if (j >= els_p) j = j - els_p;
      jj = id_width_lp'(j);
      if (!hit && req_i[jj]) begin
        hit       = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/qcl_sync_arb_ctrl.sv
// qcl_sync_arb_ctrl: shares one qcl_sync_dff channel among els_p requesters.
// Define QCL_SYNC_ARB_STATS_EN to add the stat_cnt_o accepted-word counter.
module qcl_sync_arb_ctrl
  import qcl_sync_arb_pkg::*;
#(
  parameter int els_p = 4,
  parameter int width_p = 8,
  parameter int hold_cycles_p = 4,
  localparam int id_width_lp = id_width(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [els_p-1:0]         req_v_i,
  input  logic [els_p*width_p-1:0] req_data_i,
  output logic [els_p-1:0]         req_ready_o,
  output logic [width_p-1:0]       sync_data_o,
  output logic [id_width_lp-1:0]   sync_id_o,
  output logic                     sync_toggle_o,
  output logic                     busy_o
`ifdef QCL_SYNC_ARB_STATS_EN
  ,
  output logic [15:0]              stat_cnt_o
`endif
);

  localparam int cnt_w_lp = $clog2(hold_cycles_p);

  state_e                 state_r;
  logic [cnt_w_lp-1:0]    cnt_r;
  logic [id_width_lp-1:0] ptr_r;
  logic [id_width_lp-1:0] ptr_nx;
  logic [els_p-1:0]       gnt;
  logic [id_width_lp-1:0] idx;
  logic                   grant;
  logic [width_p-1:0]     lane [els_p];

  qcl_rr_arb #(
    .els_p(els_p)
  ) u_rr (
    .req_i(req_v_i),
    .ptr_i(ptr_r),
    .gnt_o(gnt),
    .idx_o(idx)
  );

  // Split the flat data bus into per-requester lanes.
  always_comb begin
    for (int i = 0; i < els_p; i++) begin
      lane[i] = req_data_i[i*width_p +: width_p];
    end
  end

  // Grant only when the channel is free; reset masks ready at once.
  always_comb begin
    grant = reset_n_i && (|req_v_i)
         && ((state_r == IDLE) || (cnt_r == '0));
    req_ready_o = grant ? gnt : '0;
    ptr_nx = (idx == id_width_lp'(els_p - 1)) ? '0 : idx + 1'b1;
  end

  assign busy_o = (state_r == HOLD);

  // Launch a word on grant, then hold it for hold_cycles_p cycles.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      ptr_r         <= '0;
      sync_data_o   <= '0;
      sync_id_o     <= '0;
      sync_toggle_o <= 1'b0;
    end else if (grant) begin
      state_r       <= HOLD;
      cnt_r         <= cnt_w_lp'(hold_cycles_p - 1);
      ptr_r         <= ptr_nx;
      sync_data_o   <= lane[idx];
      sync_id_o     <= idx;
      sync_toggle_o <= ~sync_toggle_o;
    end else if (state_r == HOLD) begin
      if (cnt_r == '0) state_r <= IDLE;
      else             cnt_r   <= cnt_r - 1'b1;
    end
  end

`ifdef QCL_SYNC_ARB_STATS_EN
  logic [15:0] stat_cnt_r;

  // Count accepted words; wraps naturally at 16 bits.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) stat_cnt_r <= '0;
    else if (grant) stat_cnt_r <= stat_cnt_r + 16'd1;
  end

  assign stat_cnt_o = stat_cnt_r;
`endif

endmodule
